// File: rtl/array_wr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// array_wr_pkg : shared constants and round-robin pointer type for array_wr_arb4
// Revision: 1.0
// ---------------------------------------------------------------------------
package array_wr_pkg;

  localparam int NCLIENT       = 4;
  localparam int DEF_ADDRBIT   = 9;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_FIFODEPTH = 2;
  localparam int DEF_CNTBIT    = 3;

  // Client n is encoded as n-1 so the 2-bit pointer wraps 4 -> 1 for free.
  typedef enum logic [1:0] {
    RR_C1 = 2'd0,
    RR_C2 = 2'd1,
    RR_C3 = 2'd2,
    RR_C4 = 2'd3
  } rr_ptr_e;

  function automatic rr_ptr_e rr_next(input rr_ptr_e p);
    return rr_ptr_e'(p + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/array_wr_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// array_wr_fifo : per-client in-order {addr,data} queue, FIFODEPTH entries
// Revision: 1.0
// ---------------------------------------------------------------------------
module array_wr_fifo
  import array_wr_pkg::*;
#(
  parameter int ADDRBIT   = DEF_ADDRBIT,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FIFODEPTH = DEF_FIFODEPTH,
  parameter int CNTBIT    = DEF_CNTBIT
) (
  input  logic                     rst_,
  input  logic                     wclk,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDRBIT+WIDTH-1:0] din,
  output logic [ADDRBIT+WIDTH-1:0] head,
  output logic [CNTBIT-1:0]        cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int DW     = ADDRBIT + WIDTH;
  localparam int PTRBIT = $clog2(FIFODEPTH);
  localparam logic [PTRBIT-1:0] LAST = PTRBIT'(FIFODEPTH - 1);

  logic [DW-1:0]     mem_q [FIFODEPTH];
  logic [DW-1:0]     mem_d [FIFODEPTH];
  logic [PTRBIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRBIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTBIT-1:0] cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full    = (cnt_q == CNTBIT'(FIFODEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < FIFODEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow:  assert property (@(posedge wclk) disable iff (!rst_) cnt_q <= CNTBIT'(FIFODEPTH));
  a_no_overpush:  assert property (@(posedge wclk) disable iff (!rst_) !(push && full));
  a_no_underflow: assert property (@(posedge wclk) disable iff (!rst_) !(pop && empty));
`endif

endmodule
`default_nettype wire

// File: rtl/array_wr_arb4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// array_wr_arb4 : four-client round-robin serialiser onto a single array write port
// Revision: 1.0
// ---------------------------------------------------------------------------
module array_wr_arb4
  import array_wr_pkg::*;
#(
  parameter int ADDRBIT   = DEF_ADDRBIT,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FIFODEPTH = DEF_FIFODEPTH,
  parameter int CNTBIT    = DEF_CNTBIT
) (
  input  logic               rst_,
  input  logic               wclk,
  input  logic               vld1,
  input  logic               vld2,
  input  logic               vld3,
  input  logic               vld4,
  input  logic [ADDRBIT-1:0] adr1,
  input  logic [ADDRBIT-1:0] adr2,
  input  logic [ADDRBIT-1:0] adr3,
  input  logic [ADDRBIT-1:0] adr4,
  input  logic [WIDTH-1:0]   dat1,
  input  logic [WIDTH-1:0]   dat2,
  input  logic [WIDTH-1:0]   dat3,
  input  logic [WIDTH-1:0]   dat4,
  output logic               rdy1,
  output logic               rdy2,
  output logic               rdy3,
  output logic               rdy4,
  output logic [ADDRBIT-1:0] wa,
  output logic               we,
  output logic [WIDTH-1:0]   di,
  output logic [CNTBIT-1:0]  cnt1,
  output logic [CNTBIT-1:0]  cnt2,
  output logic [CNTBIT-1:0]  cnt3,
  output logic [CNTBIT-1:0]  cnt4,
  output logic               busy
);

  localparam int DW = ADDRBIT + WIDTH;

  logic [NCLIENT-1:0] vld, push, pop, full, empty;
  logic [DW-1:0]      din  [NCLIENT];
  logic [DW-1:0]      head [NCLIENT];
  logic [CNTBIT-1:0]  cnt  [NCLIENT];

  assign vld    = {vld4, vld3, vld2, vld1};
  assign din[0] = {adr1, dat1};
  assign din[1] = {adr2, dat2};
  assign din[2] = {adr3, dat3};
  assign din[3] = {adr4, dat4};

  // Ready depends on occupancy only, so a full FIFO never takes a push in its pop cycle.
  assign rdy1 = ~full[0];
  assign rdy2 = ~full[1];
  assign rdy3 = ~full[2];
  assign rdy4 = ~full[3];
  assign cnt1 = cnt[0];
  assign cnt2 = cnt[1];
  assign cnt3 = cnt[2];
  assign cnt4 = cnt[3];

  generate
    for (genvar i = 0; i < NCLIENT; i++) begin : g_fifo
      assign push[i] = vld[i] & ~full[i];
      array_wr_fifo #(
        .ADDRBIT  (ADDRBIT),
        .WIDTH    (WIDTH),
        .FIFODEPTH(FIFODEPTH),
        .CNTBIT   (CNTBIT)
      ) u_fifo (
        .rst_ (rst_),
        .wclk (wclk),
        .push (push[i]),
        .pop  (pop[i]),
        .din  (din[i]),
        .head (head[i]),
        .cnt  (cnt[i]),
        .full (full[i]),
        .empty(empty[i])
      );
    end
  endgenerate

  rr_ptr_e            ptr_q, ptr_d;
  logic               we_q, we_d;
  logic [ADDRBIT-1:0] wa_q, wa_d;
  logic [WIDTH-1:0]   di_q, di_d;
  logic               gnt_vld;
  logic [1:0]         gnt_idx;
  logic [1:0]         scan_idx;

  // First non-empty FIFO at or after the pointer, wrapping through the 2-bit index.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = ptr_q;
    scan_idx = '0;
    for (int k = 0; k < NCLIENT; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!gnt_vld && !empty[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign pop = gnt_vld ? (NCLIENT'(1) << gnt_idx) : '0;

  always_comb begin
    we_d  = gnt_vld;
    wa_d  = wa_q;
    di_d  = di_q;
    ptr_d = ptr_q;
    if (gnt_vld) begin
      {wa_d, di_d} = head[gnt_idx];
      ptr_d        = rr_next(rr_ptr_e'(gnt_idx));
    end
  end

  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      ptr_q <= RR_C1;
      we_q  <= 1'b0;
      wa_q  <= '0;
      di_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      wa_q  <= wa_d;
      di_q  <= di_d;
    end
  end

  assign we   = we_q;
  assign wa   = wa_q;
  assign di   = di_q;
  assign busy = ~&empty | we_q;

endmodule
`default_nettype wire

// File: doc/array_wr_arb4.md
Name: array_wr_arb4

Overview:
- Write-side front end for a 1-write/N-read register array. Collects write requests from four independent clients on the same wclk domain and serialises them onto the array's single write port (wa/we/di).
- Each client gets a small in-order FIFO with valid/ready flow control. A round-robin arbiter drains the FIFOs at one write per cycle.
- Outputs are registered and connect directly to the array's write port.

Parameters:
- ADDRBIT, 9, width of write address.
- WIDTH, 32, width of write data.
- FIFODEPTH, 2, entries per client FIFO; legal values 2..8.
- CNTBIT, 3, width of per-client occupancy count; must satisfy 2^CNTBIT > FIFODEPTH.

Ports:
- rst_  in  1  asynchronous reset, active low.
- wclk  in  1  clock for all logic.
- vld1..vld4  in  1 each  client n write request valid.
- adr1..adr4  in  ADDRBIT each  client n write address.
- dat1..dat4  in  WIDTH each  client n write data.
- rdy1..rdy4  out  1 each  client n may push this cycle.
- wa  out  ADDRBIT  registered write address to array.
- we  out  1  registered write enable to array.
- di  out  WIDTH  registered write data to array.
- cnt1..cnt4  out  CNTBIT each  client n FIFO occupancy.
- busy  out  1  any FIFO non-empty or we asserted.

Behaviour:
- Reset: rst_ is asynchronous and active low; wclk is the only clock.
  - On reset, all FIFOs are empty and cnt1..cnt4 = 0.
  - we = 0, wa = 0, di = 0.
  - Round-robin pointer = client 1, busy = 0.
  - rdy1..rdy4 = 1 immediately after reset release.
- Handshake:
  - rdyn = (cntn != FIFODEPTH). It is combinational from the count only, with no dependence on vldn.
  - A push occurs at a wclk edge when vldn & rdyn are both high. adrn and datn are captured at that edge.
  - vldn while rdyn = 0 is ignored; nothing is captured and nothing is dropped silently, so the client must hold the request.
- Arbitration (combinational from FIFO state, registered outputs):
  - Eligible clients are those with a non-empty FIFO.
  - The grant goes to the first eligible client scanning from the pointer upward, with wrap 4 to 1.
  - On a grant to client g, at the next edge:
    - the FIFO head is popped;
    - wa/di take the head's address and data, and we = 1;
    - the pointer becomes g+1 (4 wraps to 1).
  - With no eligible client: we = 0 at the next edge; wa/di hold their previous values; the pointer is unchanged.
- Latency: a push at edge E makes we = 1 from edge E+1 at the earliest, when that client wins. The array commits the write at E+2.
- Ordering: per-client order is strict FIFO. Across clients there is no ordering guarantee beyond round-robin.
- Fairness: with all four clients continuously backlogged, grants follow the sequence 1,2,3,4,1,…. No client waits more than 3 grants once non-empty.
- Throughput: one write per cycle sustained while any FIFO is non-empty.
- Simultaneous push and pop on the same FIFO in one cycle:
  - cntn is unchanged.
  - This is allowed even when cntn = FIFODEPTH is false. Because rdyn ignores the pop, a full FIFO does not accept a push in the cycle it is popped.
- Counts: cntn = cntn + push − pop. It never exceeds FIFODEPTH and never underflows; the RTL asserts both under simulation.
- Same address from two clients in consecutive grants: both writes are issued, in grant order, and the last one wins in the array. No coalescing.
- busy = (cnt1|cnt2|cnt3|cnt4 != 0) | we.
- Reset mid-operation: all queued writes are discarded. we deasserts asynchronously with rst_. No partial write is issued after release.

Decomposition:
- Shared package array_wr_pkg holds:
  - client-count constant NCLIENT = 4;
  - the round-robin pointer encoding, 2-bit with client n encoded as n−1;
  - default ADDRBIT/WIDTH/FIFODEPTH constants.
- One sub-module, array_wr_fifo: a synchronous FIFO of {addr,data}, FIFODEPTH entries.
  - Inputs: push, pop, din.
  - Outputs: head, cnt, full, empty.
  - Reset is asynchronous and active low.
  - Instantiated four times; the arbiter and output registers live in the top.

Test Plan:
- Reset with vld1..4 = 1: while rst_ = 0, we = 0, wa = 0, di = 0, cnt all 0, and no push occurs. After release, rdy1..4 = 1.
- Single write: client 2 pushes adr = 0x05, dat = 0xDEADBEEF at edge E. Then we = 1, wa = 0x05, di = 0xDEADBEEF from E+1 for exactly one cycle, cnt2 returns to 0, and busy is 0 at E+2.
- All four clients push one write at the same edge with adr = 1,2,3,4 and pointer = 1. Required response:
  - writes are issued in order 1,2,3,4 on consecutive cycles;
  - we is high for 4 cycles, then the pointer returns to 1.
- Backpressure with FIFODEPTH = 2: client 3 holds vld3 while client 1 is continuously backlogged.
  - Client 3 may push 2 entries, after which rdy3 = 0.
  - Client 3 is granted at most every 2nd cycle, alternating with client 1.
  - cnt3 never exceeds 2, and client 3's data order is preserved.
- Simultaneous push/pop: client 4 has cnt4 = 1 and pushes in the same cycle its head is granted. cnt4 stays 1, and the next granted write carries the newly pushed data.
- Mid-stream reset: three writes are queued and rst_ is asserted for one cycle. we drops immediately, all cnt = 0, and no stale write appears after release.
